// File: rtl/prio_arbiter.sv
// N-way arbiter with registered grant, hold/release handshake, fixed or round-robin mode.
// Optional forced release after MAX_HOLD cycles is built when ARB_TIMEOUT_EN is defined.
module prio_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 mode,
  input  logic                 done,
  output logic [$clog2(N)-1:0] grant,
  output logic [N-1:0]         grant_onehot,
  output logic                 grant_valid,
  output logic                 timeout
);

  localparam int W = $clog2(N);

  if (N < 2 || N > 32 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("prio_arbiter: N must be 2..32 and MAX_HOLD 1..255");
  end

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   grant_q, grant_d;
  logic [N-1:0]   grant_oh_q, grant_oh_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [N-1:0]   cand;
  logic [W-1:0]   fx_idx, rr_idx, win_idx;
  logic           rr_found, win_vld;
  logic           force_rel, release_now;
  int             j;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  logic [7:0]     hold_cnt_q, hold_cnt_d;
  logic           timeout_q, timeout_d;
`endif

  always_comb begin
    // The current holder is masked out so it can never win at its own release edge.
    cand = (state_q == S_HOLD) ? (req & ~grant_oh_q) : req;
    win_vld = |cand;

    fx_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) fx_idx = W'(i);
    end

    rr_found = 1'b0;
    rr_idx   = '0;
    j        = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_q) + N - k) % N;
      if (!rr_found && cand[j]) begin
        rr_found = 1'b1;
        rr_idx   = W'(j);
      end
    end

    win_idx = mode ? rr_idx : fx_idx;

`ifdef ARB_TIMEOUT_EN
    force_rel = (state_q == S_HOLD) && !done && req[grant_q] && (hold_cnt_q == HOLD_LIM);
`else
    force_rel = 1'b0;
`endif
    release_now = (state_q == S_HOLD) && (done || !req[grant_q] || force_rel);

    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    ptr_d      = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = force_rel;
`endif

    if ((state_q == S_IDLE || release_now) && win_vld) begin
      state_d    = S_HOLD;
      grant_d    = win_idx;
      grant_oh_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
      ptr_d      = win_idx;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
    end else if (release_now) begin
      state_d    = S_IDLE;
      grant_d    = '0;
      grant_oh_d = '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
    end else if (state_q == S_HOLD) begin
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant        = grant_q;
  assign grant_onehot = grant_oh_q;
  assign grant_valid  = (state_q == S_HOLD);

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter with N=4, MAX_HOLD=4; expected values are hand-computed.
module tb_prio_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mode;
  logic       done;
  logic [1:0] grant;
  logic [3:0] grant_onehot;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  prio_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .mode         (mode),
    .done         (done),
    .grant        (grant),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_grant(input string tag, input logic vld, input int idx, input logic tmo);
    logic [3:0] oh;
    oh = vld ? (4'b0001 << idx) : 4'b0000;
    chk({tag, ".valid"},   32'(grant_valid),  32'(vld));
    chk({tag, ".grant"},   32'(grant),        vld ? 32'(idx) : 32'd0);
    chk({tag, ".onehot"},  32'(grant_onehot), 32'(oh));
    chk({tag, ".timeout"}, 32'(timeout),      32'(tmo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_seq[6];
    rr_seq = '{3, 2, 1, 0, 3, 2};
    rst  = 1'b1;
    req  = 4'b0000;
    mode = 1'b0;
    done = 1'b0;
    #1;
    exp_grant("reset", 1'b0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      exp_grant("idle", 1'b0, 0, 1'b0);
    end

    // Fixed priority, then hold against a higher-priority newcomer.
    req = 4'b0110;
    tick();
    exp_grant("fixed_first", 1'b1, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_grant("fixed_hold", 1'b1, 2, 1'b0);
    end
    req = 4'b1110;
    tick();
    exp_grant("no_preempt", 1'b1, 2, 1'b0);

    // Holder 2 withdraws: candidates 1010 -> 3.
    req = 4'b1010;
    tick();
    exp_grant("withdraw_to3", 1'b1, 3, 1'b0);
    done = 1'b1;
    tick();
    exp_grant("handover_to1", 1'b1, 1, 1'b0);
    tick();
    exp_grant("handover_to3", 1'b1, 3, 1'b0);
    req = 4'b0000;
    tick();
    exp_grant("release_idle", 1'b0, 0, 1'b0);
    tick();
    exp_grant("done_in_idle", 1'b0, 0, 1'b0);
    done = 1'b0;

    // Asynchronous reset mid-grant.
    req = 4'b0100;
    tick();
    exp_grant("pre_rst", 1'b1, 2, 1'b0);
    rst = 1'b1;
    #1;
    exp_grant("async_rst", 1'b0, 0, 1'b0);
    #1;
    rst = 1'b0;

    // Round-robin from reset pointer.
    mode = 1'b1;
    req  = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_grant($sformatf("rr%0d", i), 1'b1, rr_seq[i], 1'b0);
    end
    req = 4'b0000;
    tick();
    exp_grant("rr_idle", 1'b0, 0, 1'b0);
    done = 1'b0;
    mode = 1'b0;

    // Hold limit: grant 1 at E0, forced over to 0 at E4 when the limit is built.
    req = 4'b0011;
    tick();
    exp_grant("to_first", 1'b1, 1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_grant($sformatf("to_hold%0d", i), 1'b1, 1, 1'b0);
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    exp_grant("to_fire", 1'b1, 0, 1'b1);
    tick();
    exp_grant("to_after", 1'b1, 0, 1'b0);
`else
    exp_grant("to_none", 1'b1, 1, 1'b0);
    tick();
    exp_grant("to_none2", 1'b1, 1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
